// File: rtl/bus_decoder_arbiter.sv
// bus_decoder_arbiter: two-master arbiter, memory/peripheral decode, ready/ack handshake with timeout; define ARB_ROUND_ROBIN_EN for round-robin arbitration
module bus_decoder_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_PERIPH = 8,
  parameter logic [ADDR_WIDTH-1:0] PERIPH_BASE = 32'h80000000,
  parameter int TIMEOUT = 15
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  m0_req,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic                  m0_we,
  input  logic                  m1_req,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic                  m1_we,
  input  logic                  mem_ready,
  input  logic [NUM_PERIPH-1:0] periph_ready,
  output logic                  m0_ack,
  output logic                  m1_ack,
  output logic                  bus_err,
  output logic                  sel_mem,
  output logic [NUM_PERIPH-1:0] sel_periph,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic                  owner,
  output logic [ADDR_WIDTH-1:0] err_addr
);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2, ERR = 2'd3;
  logic [1:0] state;
  logic [7:0] cnt;
  logic grant, req_we, hit_mem, hit_periph, ready, done;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [3:0] slot;
  logic [NUM_PERIPH-1:0] dec;
`ifdef ARB_ROUND_ROBIN_EN
  logic prio;
  assign grant = m0_req && m1_req ? prio : m1_req;
`else
  assign grant = m1_req;
`endif
  assign req_addr = grant ? m1_addr : m0_addr;
  assign req_we = grant ? m1_we : m0_we;
  assign slot = req_addr[11:8];
  assign hit_mem = !req_addr[ADDR_WIDTH-1];
  assign hit_periph = req_addr[ADDR_WIDTH-1] && req_addr[ADDR_WIDTH-1:12] == PERIPH_BASE[ADDR_WIDTH-1:12]
                      && 32'(slot) < NUM_PERIPH;
  assign ready = (sel_mem && mem_ready) || |(sel_periph & periph_ready);
  assign done = ready || cnt == 8'(TIMEOUT - 1);
  assign m0_ack = (state == RESP || state == ERR) && !owner;
  assign m1_ack = (state == RESP || state == ERR) && owner;
  assign bus_err = state == ERR;
  // one-hot select for the requested peripheral slot
  always_comb begin
    dec = '0;
    for (int k = 0; k < NUM_PERIPH; k++) dec[k] = hit_periph && 32'(slot) == k;
  end
  // transfer sequencing: grant and decode in IDLE, wait for ready or timeout, then acknowledge
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      owner <= 1'b0;
      bus_addr <= '0;
      bus_we <= 1'b0;
      sel_mem <= 1'b0;
      sel_periph <= '0;
      err_addr <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      prio <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: if (m0_req || m1_req) begin
          owner <= grant;
          bus_addr <= req_addr;
          bus_we <= req_we;
          sel_mem <= hit_mem;
          sel_periph <= dec;
          cnt <= '0;
          state <= hit_mem || hit_periph ? ACCESS : ERR;
        end
        ACCESS: begin
          cnt <= cnt + 8'd1;
          state <= ready ? RESP : done ? ERR : ACCESS;
          if (done) begin
            sel_mem <= 1'b0;
            sel_periph <= '0;
          end
        end
        default: begin
          if (state == ERR) err_addr <= bus_addr;
          cnt <= '0;
          state <= IDLE;
`ifdef ARB_ROUND_ROBIN_EN
          prio <= !owner;
`endif
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bus_decoder_arbiter.sv
// tb_bus_decoder_arbiter: directed and randomized transfers checked against a transaction-level model
module tb_bus_decoder_arbiter;
  localparam int NP = 8, TO = 15;
  localparam logic [31:0] PB = 32'h80000000;
  logic clock = 0, reset_n = 0;
  logic m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0, mem_ready = 0;
  logic [31:0] m0_addr = 0, m1_addr = 0;
  logic [NP-1:0] periph_ready = 0;
  logic m0_ack, m1_ack, bus_err, sel_mem, bus_we, owner;
  logic [NP-1:0] sel_periph;
  logic [31:0] bus_addr, err_addr;
  int checks = 0, errors = 0;
  bit fav_m1 = 1;
  always #5 clock = ~clock;
  bus_decoder_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we),
    .mem_ready(mem_ready), .periph_ready(periph_ready),
    .m0_ack(m0_ack), .m1_ack(m1_ack), .bus_err(bus_err),
    .sel_mem(sel_mem), .sel_periph(sel_periph), .bus_we(bus_we),
    .bus_addr(bus_addr), .owner(owner), .err_addr(err_addr)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  // -1 memory, 0..NP-1 peripheral slot, -2 unmapped
  function automatic int target(input logic [31:0] a);
    if (a < PB) return -1;
    if (a - PB < 32'(NP * 256)) return int'((a - PB) / 256);
    return -2;
  endfunction
  task automatic issue(input bit m, input logic [31:0] a, input bit we);
    if (m) begin m1_req = 1; m1_addr = a; m1_we = we; end
    else begin m0_req = 1; m0_addr = a; m0_we = we; end
  endtask
  // run one transfer from the requests currently asserted; d = ACCESS cycle index where ready rises
  task automatic serve(input int d);
    logic who, we;
    logic [31:0] a;
    logic [NP-1:0] exp_p;
    int t, n;
    bit err;
`ifdef ARB_ROUND_ROBIN_EN
    who = m0_req && m1_req ? fav_m1 : m1_req;
`else
    who = m1_req;
`endif
    a = who ? m1_addr : m0_addr;
    we = who ? m1_we : m0_we;
    t = target(a);
    exp_p = t >= 0 ? NP'(1 << t) : '0;
    @(posedge clock); #1;
    err = 1;
    if (t != -2) begin
      check("owner", 32'(owner), 32'(who));
      check("bus_addr", bus_addr, a);
      check("bus_we", 32'(bus_we), 32'(we));
      n = d < TO ? d + 1 : TO;
      err = d >= TO;
      for (int i = 0; i < n; i++) begin
        check("sel_mem_hold", 32'(sel_mem), 32'(t == -1));
        check("sel_periph_hold", 32'(sel_periph), 32'(exp_p));
        check("ack_early", 32'({m0_ack, m1_ack}), 0);
        mem_ready = t == -1 ? i == d : 1'($urandom);
        periph_ready = NP'($urandom);
        if (t >= 0) periph_ready[t] = i == d;
        @(posedge clock); #1;
      end
      mem_ready = 0;
      periph_ready = 0;
    end
    check("m0_ack", 32'(m0_ack), 32'(!who));
    check("m1_ack", 32'(m1_ack), 32'(who));
    check("bus_err", 32'(bus_err), 32'(err));
    check("sel_clear", 32'({sel_mem, sel_periph}), 0);
    if (who) m1_req = 0; else m0_req = 0;
    fav_m1 = !who;
    @(posedge clock); #1;
    check("ack_single", 32'({m0_ack, m1_ack}), 0);
    if (err) check("err_addr", err_addr, a);
  endtask
  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0: return {1'b0, 31'($urandom)};
      1: return PB + 32'($urandom_range(0, NP - 1) * 256) + 32'($urandom_range(0, 255));
      2: return PB + 32'($urandom_range(NP, 15) * 256) + 32'($urandom_range(0, 255));
      default: return PB | 32'h00010000 | 32'($urandom);
    endcase
  endfunction
  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("rst_outputs", 32'({m0_ack, m1_ack, bus_err, sel_mem, sel_periph, bus_we, owner}), 0);
    check("rst_addr", bus_addr, 0);
    reset_n = 1;
    issue(0, 32'h00000040, 0); serve(0);
    issue(1, 32'h80000310, 1); serve(3);
    issue(0, 32'h80000900, 0); serve(0);
    issue(0, 32'h80000100, 0); serve(40);
    issue(0, 32'h00001000, 1); serve(TO - 1);
    issue(1, 32'h90000200, 0); serve(0);
    for (int r = 0; r < 4; r++) begin
      issue(0, 32'h00000100 + 32'(r), 0);
      issue(1, 32'h80000000 + 32'(r * 256), 1);
      serve(r);
    end
    while (m0_req || m1_req) serve(1);
    issue(0, 32'h80000200, 0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset_n = 0;
    @(posedge clock); #1;
    check("rst_mid_sel", 32'({sel_mem, sel_periph}), 0);
    check("rst_mid_ack", 32'({m0_ack, m1_ack, bus_err}), 0);
    reset_n = 1;
    m0_req = 0;
    fav_m1 = 1;
    @(posedge clock); #1;
    check("rst_idle_ack", 32'({m0_ack, m1_ack}), 0);
    issue(0, 32'h80000500, 1); serve(2);
    for (int r = 0; r < 200; r++) begin
      if (!m0_req && $urandom_range(0, 1)) issue(0, rand_addr(), 1'($urandom));
      if (!m1_req && $urandom_range(0, 1)) issue(1, rand_addr(), 1'($urandom));
      if (!m0_req && !m1_req) issue(1'($urandom), rand_addr(), 1'($urandom));
      serve($urandom_range(0, 17));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
